// File: rtl/ex_muldiv_unit_pkg.sv
// Purpose: shared constants, types and decode helpers for the EX-stage
//          multiply/divide unit (func codes, FSM states, operation kind).
// Ports:   none (package).
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operation kind latched at start of an iterative op
    typedef struct packed {
        logic is_div;
        logic is_signed;
    } op_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    // Any instruction that touches HI/LO or the iterative datapath
    function automatic logic is_hilo(input logic [5:0] f);
        return is_muldiv(f) || (f == FN_MFHI) || (f == FN_MFLO) ||
               (f == FN_MTHI) || (f == FN_MTLO);
    endfunction

    function automatic op_t decode_op(input logic [5:0] f);
        op_t op;
        op.is_div    = (f == FN_DIV)  || (f == FN_DIVU);
        op.is_signed = (f == FN_MULT) || (f == FN_DIV);
        return op;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter.sv
// Purpose: iterative datapath: shift-add multiplier (64-bit accumulator) and
//          restoring divider (33-bit partial remainder), one step per cycle.
// Ports:   clk, i_rst_n (async active-low), i_start (latch operands),
//          i_step (advance one iteration), i_op (kind), i_a/i_b (operands),
//          o_hi_c/o_lo_c (final result as it would be after the current step).
module ex_muldiv_unit_iter
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_step,
    input  op_t             i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi_c,
    output logic [XLEN-1:0] o_lo_c
);

    // Low half of r_acc is the multiplier (mul) or dividend/quotient (div)
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_opb;
    logic              r_is_div;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_b_zero;

    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN+1:0]   w_shift;
    logic [XLEN+1:0]   w_diff;
    logic              w_borrow;
    logic [XLEN:0]     w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_quo_fix;

    assign w_a_abs = (i_op.is_signed && i_a[XLEN-1]) ? XLEN'(-i_a) : i_a;
    assign w_b_abs = (i_op.is_signed && i_b[XLEN-1]) ? XLEN'(-i_b) : i_b;

    // Multiply step: conditional add into upper half, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : (XLEN+1)'(0));
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod     = r_neg_res ? (2*XLEN)'(-w_mul_next) : w_mul_next;

    // Divide step: trial subtract; the top bit of the difference is the borrow
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_diff     = w_shift - {2'b00, r_opb};
    assign w_borrow   = w_diff[XLEN+1];
    assign w_rem_next = w_borrow ? w_shift[XLEN:0] : w_diff[XLEN:0];
    assign w_quo_next = {r_acc[XLEN-2:0], ~w_borrow};

    // With a zero divisor every trial succeeds, so the remainder ends as |a|
    // and its sign fix restores the raw dividend for HI.
    assign w_rem_fix = r_neg_rem ? XLEN'(-w_rem_next[XLEN-1:0]) : w_rem_next[XLEN-1:0];
    assign w_quo_fix = r_neg_res ? XLEN'(-w_quo_next) : w_quo_next;

    assign o_hi_c = r_is_div ? w_rem_fix : w_prod[2*XLEN-1:XLEN];
    assign o_lo_c = r_is_div ? (r_b_zero ? '1 : w_quo_fix) : w_prod[XLEN-1:0];

    // Operand latch and per-cycle iteration
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
        end else if (i_start) begin
            r_acc     <= {(XLEN)'(0), w_a_abs};
            r_rem     <= '0;
            r_opb     <= w_b_abs;
            r_is_div  <= i_op.is_div;
            r_neg_res <= i_op.is_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_rem <= i_op.is_signed && i_a[XLEN-1];
            r_b_zero  <= (i_b == '0);
        end else if (i_step) begin
            if (r_is_div) begin
                r_acc[XLEN-1:0] <= w_quo_next;
                r_rem           <= w_rem_next;
            end else begin
                r_acc <= w_mul_next;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Purpose: EX-stage multiply/divide unit owning HI/LO; runs MULT/MULTU/DIV/DIVU
//          over ITER cycles and serves MFHI/MFLO/MTHI/MTLO, stalling the pipe
//          when a HI/LO instruction arrives while busy.
// Ports:   clk, reset (async active-low), valid, func, src_a, src_b (inputs);
//          stall (comb), busy, mf_data (comb), hi, lo (outputs).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [5:0]      func,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] mf_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;

    logic             w_start;
    logic             w_step;
    logic             w_done;
    logic [XLEN-1:0]  w_res_hi;
    logic [XLEN-1:0]  w_res_lo;

    assign w_start = (r_state == ST_IDLE) && valid && is_muldiv(func);
    assign w_step  = (r_state == ST_RUN);
    assign w_done  = w_step && (r_cnt == CNT_W'(ITER - 1));

    ex_muldiv_unit_iter u_iter (
        .clk     (clk),
        .i_rst_n (reset),
        .i_start (w_start),
        .i_step  (w_step),
        .i_op    (decode_op(func)),
        .i_a     (src_a),
        .i_b     (src_b),
        .o_hi_c  (w_res_hi),
        .o_lo_c  (w_res_lo)
    );

    // Control FSM, step counter and HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (valid && (func == FN_MTHI)) begin
                        r_hi <= src_a;
                    end else if (valid && (func == FN_MTLO)) begin
                        r_lo <= src_a;
                    end
                end
                ST_RUN: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign stall = busy && valid && is_hilo(func);
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        mf_data = '0;
        if (valid && (func == FN_MFHI)) begin
            mf_data = r_hi;
        end else if (valid && (func == FN_MFLO)) begin
            mf_data = r_lo;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Purpose: scoreboard bench for ex_muldiv_unit; a driver issues directed and
//          random instructions while a negedge monitor checks stall, MF data,
//          busy length and the HI/LO results against a plain-arithmetic model.
module tb_ex_muldiv_unit;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [5:0]  func;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] res_q[$];
    logic [31:0] mf_q[$];

    int   busy_len;
    logic prev_busy;

    ex_muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .func    (func),
        .src_a   (src_a),
        .src_b   (src_b),
        .stall   (stall),
        .busy    (busy),
        .mf_data (mf_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Architectural result {HI,LO} from plain integer arithmetic
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            MULT:    return 64'(sa * sb);
            MULTU:   return {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h00000001;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one instruction and hold it until it leaves EX
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int guard;
        valid = 1'b1;
        func  = f;
        src_a = a;
        src_b = b;
        case (f)
            MFHI: mf_q.push_back(m_hi);
            MFLO: mf_q.push_back(m_lo);
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            MULT, MULTU, DIV, DIVU: begin
                r = ref_op(f, a, b);
                res_q.push_back(r);
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
            default: ;
        endcase
        guard = 0;
        @(negedge clk);
        while (stall && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail_now("stall_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail_now("busy_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: decoupled from the driver, pops expectations as the DUT responds
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            check("stall", 64'(stall),
                  64'(busy && valid && (func inside {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU})));
            if (valid && !stall && (func == MFHI || func == MFLO)) begin
                if (mf_q.size() == 0) fail_now("mf_unexpected");
                else check("mf_data", 64'(mf_data), 64'(mf_q.pop_front()));
            end
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                check("busy_len", 64'(busy_len), 64'd32);
                if (res_q.size() == 0) fail_now("result_unexpected");
                else check("hilo", {hi, lo}, res_q.pop_front());
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] kind;
        logic [5:0] md_funcs[4];
        md_funcs = '{MULT, MULTU, DIV, DIVU};
        reset = 1'b0;
        valid = 1'b0;
        func  = 6'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        busy_len  = 0;
        prev_busy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with known literal answers
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);

        issue(MULT, 32'hFFFFFFFD, 32'd7);
        issue(MFLO, 32'd0, 32'd0);
        wait_idle();
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        issue(DIVU, 32'd100, 32'd7);
        wait_idle();
        check("divu", {hi, lo}, {32'd2, 32'd14});

        issue(DIVU, 32'd5, 32'd0);
        wait_idle();
        check("divu_zero", {hi, lo}, {32'd5, 32'hFFFFFFFF});

        issue(MTHI, 32'h1234, 32'd0);
        issue(MFHI, 32'd0, 32'd0);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        issue(MFHI, 32'd0, 32'd0);
        issue(MFLO, 32'd0, 32'd0);
        issue(DIV, 32'hFFFFFFF9, 32'd0);
        issue(MULTU, 32'd3, 32'd4);
        issue(MFLO, 32'd0, 32'd0);

        // Random mix, including back-to-back ops that must stall
        repeat (60) begin
            kind = 6'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: issue(md_funcs[$urandom_range(0, 3)], pick(), pick());
                4:          issue(MTHI, pick(), 32'd0);
                5:          issue(MTLO, pick(), 32'd0);
                6:          issue(MFHI, 32'd0, 32'd0);
                7:          issue(MFLO, 32'd0, 32'd0);
                8:          issue(ADD, pick(), pick());
                default: begin
                    valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            endcase
        end
        wait_idle();

        // Reset during an operation discards it
        issue(MULTU, 32'd3, 32'd4);
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        res_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(MULTU, 32'd3, 32'd4);
        wait_idle();
        check("after_rst_lo", 64'(lo), 64'd12);
        issue(MFLO, 32'd0, 32'd0);
        issue(MFHI, 32'd0, 32'd0);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("res_q_drained", 64'(res_q.size()), 64'd0);
        check("mf_q_drained", 64'(mf_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
